// File: rtl/controle_jogo_if.sv
// ============================================================================
// Module   : controle_jogo_if
// Purpose  : Bundles the game sequencer's button, password and guess inputs
//            together with its status outputs.
// Ports    : master - drives buttons, new passwords and guesses; reads status
//            slave  - the sequencer side (controle_jogo)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface controle_jogo_if;
  logic       iniciar;
  logic       confirmar;
  logic [3:0] senha_a_in;
  logic [2:0] senha_b_in;
  logic [3:0] tentativa_a;
  logic [2:0] tentativa_b;
  logic [3:0] senha_a;
  logic [2:0] senha_b;
  logic       fase_b_ativa;
  logic [2:0] estado;
  logic [3:0] tentativas_restantes;
  logic       erro_flash;
  logic       vitoria;
  logic       derrota;

  modport master (
    output iniciar, confirmar, senha_a_in, senha_b_in, tentativa_a, tentativa_b,
    input  senha_a, senha_b, fase_b_ativa, estado, tentativas_restantes,
           erro_flash, vitoria, derrota
  );

  modport slave (
    input  iniciar, confirmar, senha_a_in, senha_b_in, tentativa_a, tentativa_b,
    output senha_a, senha_b, fase_b_ativa, estado, tentativas_restantes,
           erro_flash, vitoria, derrota
  );
endinterface

`default_nettype wire

// File: rtl/controle_jogo.sv
// ============================================================================
// Module   : controle_jogo
// Purpose  : Two-phase password game sequencer. Latches the secret passwords
//            on start, judges confirmed guesses, moves from phase A to phase
//            B, counts down the shared attempt budget, holds a wrong-guess
//            flash and flags victory or defeat. All outputs are registered.
// Ports    : clk   - system clock
//            reset - synchronous, active-high reset
//            bus   - controle_jogo_if.slave (buttons, passwords, guesses in;
//                    latched passwords, phase, state, attempts, flags out)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module controle_jogo #(
  parameter int MAX_TENTATIVAS = 8,
  parameter int TEMPO_ERRO     = 25000000
) (
  input  wire logic     clk,
  input  wire logic     reset,
  controle_jogo_if.slave bus
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    FASE_A  = 3'd1,
    FASE_B  = 3'd2,
    ERRO    = 3'd3,
    VITORIA = 3'd4,
    DERROTA = 3'd5
  } state_t;

  localparam logic [3:0]  MAX_CNT  = 4'(MAX_TENTATIVAS);
  localparam logic [24:0] ERRO_INI = 25'(TEMPO_ERRO - 1);

  state_t      state, state_n;
  logic [3:0]  senha_a, senha_a_n;
  logic [2:0]  senha_b, senha_b_n;
  logic [3:0]  tentativas, tentativas_n;
  logic [24:0] err_cnt, err_cnt_n;
  logic        ret_b, ret_b_n;          // phase to resume after the flash
  logic        erro_flash, erro_flash_n;
  logic        fase_b, fase_b_n;
  logic        vitoria, vitoria_n;
  logic        derrota, derrota_n;
  logic        prev_ini, prev_conf;

  logic        rise_ini, rise_conf, guess_ok;

  assign rise_ini  = bus.iniciar   & ~prev_ini;
  assign rise_conf = bus.confirmar & ~prev_conf;

  // Only one of the two comparisons matters in each playing phase.
  assign guess_ok = (state == FASE_B) ? (bus.tentativa_b == senha_b)
                                      : (bus.tentativa_a == senha_a);

  always_comb begin
    state_n      = state;
    senha_a_n    = senha_a;
    senha_b_n    = senha_b;
    tentativas_n = tentativas;
    err_cnt_n    = err_cnt;
    ret_b_n      = ret_b;

    case (state)
      OCIOSO, VITORIA, DERROTA: begin
        // confirmar is simply not looked at here, so a simultaneous
        // confirm never competes with the start.
        if (rise_ini) begin
          senha_a_n    = bus.senha_a_in;
          senha_b_n    = bus.senha_b_in;
          tentativas_n = MAX_CNT;
          ret_b_n      = 1'b0;
          state_n      = FASE_A;
        end
      end
      FASE_A, FASE_B: begin
        if (rise_conf) begin
          if (guess_ok) begin
            state_n = (state == FASE_A) ? FASE_B : VITORIA;
          end else if (tentativas == 4'd1) begin
            // Last attempt spent: straight to defeat, no flash.
            tentativas_n = 4'd0;
            state_n      = DERROTA;
          end else begin
            tentativas_n = tentativas - 4'd1;
            ret_b_n      = (state == FASE_B);
            err_cnt_n    = ERRO_INI;
            state_n      = ERRO;
          end
        end
      end
      ERRO: begin
        // Counter loaded with TEMPO_ERRO-1 on entry, so ERRO lasts exactly
        // TEMPO_ERRO cycles. Confirm rises here are dropped.
        if (err_cnt == 25'd0) begin
          state_n = ret_b ? FASE_B : FASE_A;
        end else begin
          err_cnt_n = err_cnt - 25'd1;
        end
      end
      default: state_n = OCIOSO;        // unused codes 6 and 7
    endcase

    // Flags are decoded from the next state so they are registered alongside it.
    erro_flash_n = (state_n == ERRO);
    fase_b_n     = (state_n == FASE_B) || (state_n == VITORIA) ||
                   ((state_n == ERRO) && ret_b_n);
    vitoria_n    = (state_n == VITORIA);
    derrota_n    = (state_n == DERROTA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= OCIOSO;
      senha_a    <= 4'd0;
      senha_b    <= 3'd0;
      tentativas <= MAX_CNT;
      err_cnt    <= 25'd0;
      ret_b      <= 1'b0;
      erro_flash <= 1'b0;
      fase_b     <= 1'b0;
      vitoria    <= 1'b0;
      derrota    <= 1'b0;
      // Prev set to 1 so a button held through reset needs a release first.
      prev_ini   <= 1'b1;
      prev_conf  <= 1'b1;
    end else begin
      state      <= state_n;
      senha_a    <= senha_a_n;
      senha_b    <= senha_b_n;
      tentativas <= tentativas_n;
      err_cnt    <= err_cnt_n;
      ret_b      <= ret_b_n;
      erro_flash <= erro_flash_n;
      fase_b     <= fase_b_n;
      vitoria    <= vitoria_n;
      derrota    <= derrota_n;
      prev_ini   <= bus.iniciar;
      prev_conf  <= bus.confirmar;
    end
  end

  assign bus.senha_a              = senha_a;
  assign bus.senha_b              = senha_b;
  assign bus.fase_b_ativa         = fase_b;
  assign bus.estado               = state;
  assign bus.tentativas_restantes = tentativas;
  assign bus.erro_flash           = erro_flash;
  assign bus.vitoria              = vitoria;
  assign bus.derrota              = derrota;

endmodule

`default_nettype wire

// File: tb/tb_controle_jogo.sv
// ============================================================================
// Module   : tb_controle_jogo
// Purpose  : Self-checking bench for controle_jogo (MAX_TENTATIVAS=3,
//            TEMPO_ERRO=4). Each driven cycle pushes the expected outputs
//            from a behavioural game model; they are popped and compared
//            once the DUT has clocked.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controle_jogo;

  localparam int MAX  = 3;
  localparam int TEMPO = 4;

  typedef struct {
    logic [2:0] estado;
    logic [3:0] sa;
    logic [2:0] sb;
    logic [3:0] cnt;
    logic       flash;
    logic       fb;
    logic       vit;
    logic       der;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  controle_jogo_if bus();

  controle_jogo #(.MAX_TENTATIVAS(MAX), .TEMPO_ERRO(TEMPO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  exp_t q[$];

  // Stimulus levels held between cycles
  logic       rst_v, ini_v, conf_v;
  logic [3:0] sa_v, ta_v;
  logic [2:0] sb_v, tb_v;

  // Game model state
  int m_state, m_sa, m_sb, m_cnt, m_ecnt;
  bit m_retb, m_pi, m_pc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_wrong(input bit phase_b);
    if (m_cnt == 1) begin
      m_cnt   = 0;
      m_state = 5;
    end else begin
      m_cnt   = m_cnt - 1;
      m_retb  = phase_b;
      m_ecnt  = TEMPO - 1;
      m_state = 3;
    end
  endtask

  task automatic model_step();
    bit ri, rc;
    if (rst_v) begin
      m_state = 0; m_sa = 0; m_sb = 0; m_cnt = MAX; m_ecnt = 0;
      m_retb = 0; m_pi = 1; m_pc = 1;
    end else begin
      ri = ini_v & ~m_pi;
      rc = conf_v & ~m_pc;
      case (m_state)
        0, 4, 5: if (ri) begin
          m_sa = sa_v; m_sb = sb_v; m_cnt = MAX; m_retb = 0; m_state = 1;
        end
        1: if (rc) begin
          if (ta_v == m_sa) m_state = 2; else model_wrong(1'b0);
        end
        2: if (rc) begin
          if (tb_v == m_sb) m_state = 4; else model_wrong(1'b1);
        end
        3: if (m_ecnt == 0) m_state = m_retb ? 2 : 1;
           else m_ecnt = m_ecnt - 1;
        default: m_state = 0;
      endcase
      m_pi = ini_v;
      m_pc = conf_v;
    end
  endtask

  // One clock: drive, predict, let the DUT clock, compare.
  task automatic step();
    exp_t e, g;
    reset           = rst_v;
    bus.iniciar     = ini_v;
    bus.confirmar   = conf_v;
    bus.senha_a_in  = sa_v;
    bus.senha_b_in  = sb_v;
    bus.tentativa_a = ta_v;
    bus.tentativa_b = tb_v;
    model_step();
    e.estado = 3'(m_state);
    e.sa     = 4'(m_sa);
    e.sb     = 3'(m_sb);
    e.cnt    = 4'(m_cnt);
    e.flash  = (m_state == 3);
    e.fb     = (m_state == 2) || (m_state == 4) || (m_state == 3 && m_retb);
    e.vit    = (m_state == 4);
    e.der    = (m_state == 5);
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check_val("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      g = q.pop_front();
      check_val("estado",     32'(bus.estado),               32'(g.estado));
      check_val("senha_a",    32'(bus.senha_a),              32'(g.sa));
      check_val("senha_b",    32'(bus.senha_b),              32'(g.sb));
      check_val("tentativas", 32'(bus.tentativas_restantes), 32'(g.cnt));
      check_val("erro_flash", 32'(bus.erro_flash),           32'(g.flash));
      check_val("fase_b",     32'(bus.fase_b_ativa),         32'(g.fb));
      check_val("vitoria",    32'(bus.vitoria),              32'(g.vit));
      check_val("derrota",    32'(bus.derrota),              32'(g.der));
    end
  endtask

  task automatic pulse_conf();
    conf_v = 1'b1; step();
    conf_v = 1'b0; step();
  endtask

  task automatic pulse_ini();
    ini_v = 1'b1; step();
    ini_v = 1'b0; step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int flashes;
    int third_flash;
    rst_v = 1'b1; ini_v = 1'b0; conf_v = 1'b1;
    sa_v = 4'd0; sb_v = 3'd0; ta_v = 4'd0; tb_v = 3'd0;
    m_state = 0; m_sa = 0; m_sb = 0; m_cnt = MAX; m_ecnt = 0;
    m_retb = 0; m_pi = 1; m_pc = 1;
    #1;

    // Reset with confirmar held, then keep it held for 20 cycles
    idle(2);
    check_val("reset_estado", 32'(bus.estado), 32'd0);
    check_val("reset_cnt", 32'(bus.tentativas_restantes), 32'd3);
    rst_v = 1'b0;
    idle(20);
    check_val("held_conf_estado", 32'(bus.estado), 32'd0);
    conf_v = 1'b0; step();

    // Start with 9/5, inputs change afterwards with no effect
    sa_v = 4'd9; sb_v = 3'd5;
    pulse_ini();
    sa_v = 4'd2; sb_v = 3'd1;
    step();
    check_val("start_estado", 32'(bus.estado), 32'd1);
    check_val("start_senha_a", 32'(bus.senha_a), 32'd9);
    check_val("start_senha_b", 32'(bus.senha_b), 32'd5);

    // Correct A then correct B
    ta_v = 4'd9; pulse_conf();
    check_val("phase_b_estado", 32'(bus.estado), 32'd2);
    check_val("phase_b_flag", 32'(bus.fase_b_ativa), 32'd1);
    tb_v = 3'd5; pulse_conf();
    check_val("win_estado", 32'(bus.estado), 32'd4);
    check_val("win_flag", 32'(bus.vitoria), 32'd1);

    // New game, wrong A guess: flash lasts exactly TEMPO cycles
    sa_v = 4'd9; sb_v = 3'd5;
    pulse_ini();
    ta_v = 4'd3;
    conf_v = 1'b1; step();
    flashes = (bus.erro_flash === 1'b1) ? 1 : 0;
    conf_v = 1'b0;
    for (int i = 0; i < 10; i++) begin
      conf_v = (i == 1);
      step();
      if (bus.erro_flash === 1'b1) flashes++;
    end
    check_val("flash_cycles", 32'(flashes), 32'(TEMPO));
    check_val("after_flash_estado", 32'(bus.estado), 32'd1);
    check_val("after_flash_cnt", 32'(bus.tentativas_restantes), 32'd2);

    // Into B, then run out of attempts there (2 left)
    ta_v = 4'd9; pulse_conf();
    tb_v = 3'd0; pulse_conf(); idle(6);
    pulse_conf();
    check_val("lose_early_estado", 32'(bus.estado), 32'd5);

    // Fresh game, three wrong B guesses
    pulse_ini();
    check_val("restart_cnt", 32'(bus.tentativas_restantes), 32'd3);
    check_val("restart_derrota", 32'(bus.derrota), 32'd0);
    ta_v = 4'd9; pulse_conf();
    tb_v = 3'd1;
    third_flash = 0;
    for (int k = 0; k < 3; k++) begin
      conf_v = 1'b1; step();
      if (k == 2 && bus.erro_flash !== 1'b0) third_flash = 1;
      conf_v = 1'b0; step();
      if (k == 2 && bus.erro_flash !== 1'b0) third_flash = 1;
      if (k < 2) idle(6);
    end
    check_val("third_no_flash", 32'(third_flash), 32'd0);
    check_val("lose_estado", 32'(bus.estado), 32'd5);
    check_val("lose_cnt", 32'(bus.tentativas_restantes), 32'd0);
    check_val("lose_derrota", 32'(bus.derrota), 32'd1);
    pulse_ini();
    check_val("after_lose_cnt", 32'(bus.tentativas_restantes), 32'd3);
    check_val("after_lose_derrota", 32'(bus.derrota), 32'd0);

    // Simultaneous start and confirm in OCIOSO: start wins
    rst_v = 1'b1; step();
    rst_v = 1'b0; step();
    ta_v = 4'd0;
    ini_v = 1'b1; conf_v = 1'b1; step();
    check_val("both_estado", 32'(bus.estado), 32'd1);
    check_val("both_cnt", 32'(bus.tentativas_restantes), 32'd3);
    ini_v = 1'b0; conf_v = 1'b0; step();

    // Reset in the middle of a flash
    ta_v = 4'd3; pulse_conf();
    check_val("pre_reset_flash", 32'(bus.erro_flash), 32'd1);
    rst_v = 1'b1; step();
    check_val("mid_reset_estado", 32'(bus.estado), 32'd0);
    check_val("mid_reset_flash", 32'(bus.erro_flash), 32'd0);
    check_val("mid_reset_senha_a", 32'(bus.senha_a), 32'd0);
    check_val("mid_reset_cnt", 32'(bus.tentativas_restantes), 32'd3);
    rst_v = 1'b0; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
